// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator behind a 2-entry skid buffer.
// Decode is combinational on the input word; the decoded entry is stored on acceptance.
module imm_gen_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter bit          ZERO_ILLEG = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam int unsigned ILEN  = 32;
  localparam int unsigned FMT_W = 3;

  localparam logic [FMT_W-1:0] FMT_R     = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I     = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S     = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B     = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U     = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J     = 3'd5;
  localparam logic [FMT_W-1:0] FMT_SHAMT = 3'd6;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ILEN-1:0]  instr;
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
    logic             illegal;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, skid_q, dec;
  logic   in_ready_q;
  logic   accept, pop;
  logic   load_head, load_skid, shift_skid;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] i_imm;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign i_imm  = XLEN'($signed(in_instr[31:20]));

  // Immediate decode of the offered word
  always_comb begin
    dec         = '0;
    dec.instr   = in_instr;
    dec.fmt     = FMT_R;
    dec.illegal = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.fmt = FMT_SHAMT;
          dec.imm = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
        end else begin
          dec.fmt = FMT_I;
          dec.imm = i_imm;
        end
      end
      OP_LOAD, OP_JALR: begin
        dec.fmt = FMT_I;
        dec.imm = i_imm;
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      OP_BR: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({in_instr[31:12], 12'h000}));
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      OP_REG, OP_SYS, OP_FENCE: begin
        dec.fmt = FMT_R;
      end
      default: begin
        dec.illegal = 1'b1;
        dec.imm     = ZERO_ILLEG ? '0 : i_imm;
      end
    endcase
  end

  // Ready depends only on registered occupancy plus rst/flush, never on out_ready
  assign in_ready  = in_ready_q & ~rst & ~flush;
  assign out_valid = (state_q != S_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_FULL);
    end
  end

  // Occupancy transitions and slot load controls
  always_comb begin
    state_d    = state_q;
    load_head  = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d   = S_ONE;
          load_head = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && pop) begin
          load_head = 1'b1;
        end else if (accept) begin
          state_d   = S_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d    = S_ONE;
          shift_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d    = S_EMPTY;
      load_head  = 1'b0;
      load_skid  = 1'b0;
      shift_skid = 1'b0;
    end
  end

  // Payload slots; contents of empty slots are left as-is
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_head) begin
        head_q <= dec;
      end else if (shift_skid) begin
        head_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  assign out_instr   = head_q.instr;
  assign out_imm     = head_q.imm;
  assign out_fmt     = head_q.fmt;
  assign out_illegal = head_q.illegal;

endmodule
